processor_pw: RTL

Parametrised successor to the 8-bit accumulator processor: a multi-cycle accumulator core with configurable data width, register-file depth and program-counter width. It adds a valid/request instruction-fetch handshake with stall support, carry/zero conditional jumps and a HALT state. It sits between the instruction ROM/fetch interface and the system. Every instruction word is 8 bits, laid out as opcode[7:4] followed by operand n[3:0].

---
 rtl/processor_pw_if.sv | 24 ++
 rtl/processor_pw.sv | 135 +++++++++++++
 2 files changed

// File: rtl/processor_pw_if.sv
// Instruction-fetch handshake between the accumulator core and its ROM.
// The core is the master: it requests and addresses, the ROM answers.
interface processor_pw_if #(
    parameter int PCW = 8
);
    logic [7:0]     instruction;
    logic           instr_valid;
    logic           instr_req;
    logic [PCW-1:0] pc;

    modport master (
        input  instruction,
        input  instr_valid,
        output instr_req,
        output pc
    );

    modport slave (
        output instruction,
        output instr_valid,
        input  instr_req,
        input  pc
    );
endinterface

// File: rtl/processor_pw.sv
// Multi-cycle parametrised accumulator core: FETCH -> EXEC, with a sticky HALT.
// Instruction word is opcode[7:4], operand n[3:0].
module processor_pw #(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int PCW  = 8
) (
    input  logic           clk,
    input  logic           clb,
    processor_pw_if.master fetch,
    output logic [DW-1:0]  acc,
    output logic           zflag,
    output logic           cflag,
    output logic           halted
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [7:0]     ir_q, ir_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic           z_q, z_d;
    logic           c_q, c_d;
    logic [DW-1:0]  rf_q [NREG];
    logic [DW-1:0]  rf_d [NREG];

    logic [DW-1:0]  rf_rd [16];
    logic [3:0]     op, n;
    logic [DW-1:0]  rval, imm;
    logic [DW:0]    sum, diff;
    logic           upd_z, take;

    assign op = ir_q[7:4];
    assign n  = ir_q[3:0];

    // Unimplemented register slots read as zero.
    for (genvar i = 0; i < 16; i++) begin : g_rd
        if (i < NREG) begin : g_on
            assign rf_rd[i] = rf_q[i];
        end else begin : g_off
            assign rf_rd[i] = '0;
        end
    end

    assign rval  = rf_rd[n];
    assign imm   = {{(DW-4){1'b0}}, n};
    assign sum   = {1'b0, acc_q} + {1'b0, rval};
    assign diff  = {1'b0, acc_q} - {1'b0, rval};
    assign upd_z = (op == 4'h1) || (op == 4'h2) ||
                   ((op >= 4'h4) && (op <= 4'hA));
    assign take  = (op == 4'hB) ||
                   ((op == 4'hC) && z_q) ||
                   ((op == 4'hD) && c_q) ||
                   ((op == 4'hE) && !z_q);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        rf_d    = rf_q;
        unique case (1'b1)
            (state_q == S_FETCH): begin
                if (fetch.instr_valid) begin
                    ir_d    = fetch.instruction;
                    pc_d    = pc_q + PCW'(1);
                    state_d = S_EXEC;
                end
            end
            (state_q == S_EXEC): begin
                state_d = (op == 4'hF) ? S_HALT : S_FETCH;
                case (op)
                    4'h1: acc_d = imm;
                    4'h2: acc_d = rval;
                    4'h3: begin
                        for (int i = 0; i < NREG; i++)
                            if (n == 4'(i)) rf_d[i] = acc_q;
                    end
                    4'h4: {c_d, acc_d} = sum;
                    4'h5: begin
                        acc_d = diff[DW-1:0];
                        c_d   = diff[DW];
                    end
                    4'h6: acc_d = acc_q & rval;
                    4'h7: acc_d = acc_q | rval;
                    4'h8: acc_d = acc_q ^ rval;
                    4'h9: begin
                        c_d   = acc_q[DW-1];
                        acc_d = {acc_q[DW-2:0], 1'b0};
                    end
                    4'hA: begin
                        c_d   = acc_q[0];
                        acc_d = {1'b0, acc_q[DW-1:1]};
                    end
                    default: ;
                endcase
                // Jump target replaces the increment done at fetch.
                if (take) pc_d = rval[PCW-1:0];
                if (upd_z) z_d = (acc_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clb) begin
        if (clb) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            pc_q    <= '0;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
            rf_q    <= rf_d;
        end
    end

    assign fetch.instr_req = (state_q == S_FETCH);
    assign fetch.pc        = pc_q;
    assign acc             = acc_q;
    assign zflag           = z_q;
    assign cflag           = c_q;
    assign halted          = (state_q == S_HALT);
endmodule
